// File: rtl/ram_bridge_pkg.sv
// Shared types for the line-to-beat RAM bridge: FSM encoding and beat indexing.
package ram_bridge_pkg;

    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WBEATS,
        WAIT_ACK,
        RBEATS,
        DONE
    } state_t;

endpackage

// File: rtl/ram_line_bridge_if.sv
// Bundle of the cache-side line port and the RAM-side beat port.
// slave is the bridge's view; master is the cache + RAM environment.
interface ram_line_bridge_if #(
    parameter int RAM_ADDR_SIZE = 13,
    parameter int RAM_WORD_SIZE = 16,
    parameter int LINE_WIDTH    = 64
);
    logic                     line_req;
    logic                     line_rnw;
    logic [RAM_ADDR_SIZE-1:0] line_addr;
    logic [LINE_WIDTH-1:0]    line_wdata;
    logic                     line_ready;
    logic [LINE_WIDTH-1:0]    line_rdata;
    logic                     line_done;
    logic                     line_err;
    logic [RAM_ADDR_SIZE-1:0] ram_addr;
    logic [RAM_WORD_SIZE-1:0] ram_wdata;
    logic                     ram_avalid;
    logic                     ram_rnw;
    logic [RAM_WORD_SIZE-1:0] ram_rdata;
    logic                     ram_ack;

    modport slave (
        input  line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_ack,
        output line_ready, line_rdata, line_done, line_err,
               ram_addr, ram_wdata, ram_avalid, ram_rnw
    );

    modport master (
        output line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_ack,
        input  line_ready, line_rdata, line_done, line_err,
               ram_addr, ram_wdata, ram_avalid, ram_rnw
    );
endinterface

// File: rtl/ram_beat_shifter.sv
// Line register that shifts write beats out (low half-word first) and read beats in.
// Latency: one cycle per beat; wdata is the register's low word, line_rdata updates on commit.
// No backpressure: load/shift/commit strobes are obeyed unconditionally.
module ram_beat_shifter
    import ram_bridge_pkg::*;
#(
    parameter int RAM_WORD_SIZE = 16,
    parameter int LINE_WIDTH    = 64
) (
    input  logic                     ram_clk,
    input  logic                     ram_rst,
    input  logic                     load,
    input  logic [LINE_WIDTH-1:0]    load_data,
    input  logic                     shift,
    input  logic [RAM_WORD_SIZE-1:0] fill,
    input  logic                     commit,
    output logic [RAM_WORD_SIZE-1:0] wdata,
    output logic                     last_beat,
    output logic [LINE_WIDTH-1:0]    line_rdata
);
    localparam int NBEATS = LINE_WIDTH / RAM_WORD_SIZE;

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] shifted;
    beat_idx_t             idx_q;

    // Writes shift in zeros, reads shift the RAM beat in at the top so that
    // after NBEATS shifts beat k sits at bits [16k+15:16k].
    assign shifted   = {fill, line_q[LINE_WIDTH-1:RAM_WORD_SIZE]};
    assign wdata     = line_q[RAM_WORD_SIZE-1:0];
    assign last_beat = (idx_q == beat_idx_t'(NBEATS - 1));

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            line_q     <= '0;
            idx_q      <= '0;
            line_rdata <= '0;
        end else begin
            if (load) begin
                line_q <= load_data;
                idx_q  <= '0;
            end else if (shift) begin
                line_q <= shifted;
                idx_q  <= idx_q + beat_idx_t'(1);
            end
            if (commit) begin
                line_rdata <= shifted;
            end
        end
    end

endmodule

// File: rtl/ram_line_bridge.sv
// Converts whole-line fills/write-backs into the 16-bit RAM beat protocol with ack timeout.
// Latency: done 6 cycles after request with immediate ack, +1 per ack wait cycle.
// Backpressure: line_ready low while busy; line_req outside IDLE is ignored.
module ram_line_bridge
    import ram_bridge_pkg::*;
#(
    parameter int RAM_ADDR_SIZE = 13,
    parameter int RAM_WORD_SIZE = 16,
    parameter int LINE_WIDTH    = 64,
    parameter int TIMEOUT       = 255
) (
    input  logic             ram_clk,
    input  logic             ram_rst,
    ram_line_bridge_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     load, shift, commit, timeout_hit, last_beat;
    logic [RAM_WORD_SIZE-1:0] fill;

    // ram_rnw holds the captured direction for the whole transfer.
    assign fill = bus.ram_rnw ? bus.ram_rdata : '0;

    ram_beat_shifter #(
        .RAM_WORD_SIZE (RAM_WORD_SIZE),
        .LINE_WIDTH    (LINE_WIDTH)
    ) u_shifter (
        .ram_clk    (ram_clk),
        .ram_rst    (ram_rst),
        .load       (load),
        .load_data  (bus.line_wdata),
        .shift      (shift),
        .fill       (fill),
        .commit     (commit),
        .wdata      (bus.ram_wdata),
        .last_beat  (last_beat),
        .line_rdata (bus.line_rdata)
    );

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        shift       = 1'b0;
        commit      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.line_req) begin
                    load    = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.ram_rnw) begin
                    state_d = WAIT_ACK;
                end else begin
                    shift   = 1'b1;
                    state_d = WBEATS;
                end
            end
            WBEATS: begin
                if (last_beat) begin
                    state_d = WAIT_ACK;
                end else begin
                    shift = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.ram_ack) begin
                    if (bus.ram_rnw) begin
                        shift   = 1'b1;
                        state_d = RBEATS;
                    end else begin
                        state_d = DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            RBEATS: begin
                shift = 1'b1;
                if (last_beat) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Held at zero outside WAIT_ACK, so every wait starts counting from zero.
    always_ff @(posedge ram_clk) begin
        if (ram_rst || state_q != WAIT_ACK) begin
            cnt_q <= '0;
        end else if (!bus.ram_ack) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            bus.line_ready <= 1'b1;
            bus.line_done  <= 1'b0;
            bus.line_err   <= 1'b0;
            bus.ram_avalid <= 1'b0;
            bus.ram_rnw    <= 1'b1;
            bus.ram_addr   <= '0;
        end else begin
            bus.line_ready <= (state_d == IDLE);
            bus.line_done  <= (state_d == DONE);
            bus.line_err   <= timeout_hit;
            bus.ram_avalid <= (state_d == ADDR);
            if (load) begin
                bus.ram_addr <= bus.line_addr;
                bus.ram_rnw  <= bus.line_rnw;
            end
        end
    end

endmodule
